// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode constants and depth helper for the FIFO family
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int depth(input int addrsize);
        return 1 << addrsize;
    endfunction

endpackage

// File: rtl/fifomem_1clk.sv
// fifomem_1clk: single-clock storage array, synchronous write, asynchronous read
module fifomem_1clk
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    logic [DATASIZE-1:0] mem [depth(ADDRSIZE)];

    assign rdata = mem[raddr];

    // contents are deliberately not reset; occupancy tracking makes stale words unreachable
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy, programmable flags, sticky errors and std/FWFT read
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = 2**ADDRSIZE - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    output logic                wfull,
    output logic                walmost_full,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam int CW = ADDRSIZE + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth(ADDRSIZE));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [CW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d, mem_rdata;
    logic                overflow_q, overflow_d, underflow_q, underflow_d;
    logic                we, re;

    // flags come only from registered occupancy, never from this cycle's requests
    assign wfull         = count_q == DEPTH_C;
    assign rempty        = count_q == '0;
    assign walmost_full  = count_q >= AFULL_C;
    assign ralmost_empty = count_q <= AEMPTY_C;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign rdata         = (FWFT == FIFO_FWFT) ? mem_rdata : rdata_q;

    fifomem_1clk #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(wptr_q[ADDRSIZE-1:0]),
        .wdata(wdata),
        .raddr(rptr_q[ADDRSIZE-1:0]),
        .rdata(mem_rdata)
    );

    // accept decisions, pointer/occupancy advance, read register load and sticky error update
    always_comb begin
        we          = winc & ~wfull;
        re          = rinc & ~rempty;
        wptr_d      = we ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = re ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q + CW'(we) - CW'(re);
        rdata_d     = (FWFT == FIFO_STD && re) ? mem_rdata : rdata_q;
        overflow_d  = (overflow_q & ~clr_err) | (winc & wfull);
        underflow_d = (underflow_q & ~clr_err) | (rinc & rempty);
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO: dual-port memory array, pointer/occupancy control, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, selectable read mode (registered standard or first-word-fall-through).
- Sits beside the async FIFO as the same-domain buffering option: rate smoothing inside one clock domain, e.g. behind a CDC boundary or between pipeline stages.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE words.
- AFULL_LVL, 2**ADDRSIZE-2, walmost_full asserted when count >= AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 2, ralmost_empty asserted when count <= AEMPTY_LVL; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.

Ports:
- clk  input  1  sole clock, all logic rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- winc  input  1  write request.
- wdata  input  DATASIZE  write data.
- wfull  output  1  count == DEPTH.
- walmost_full  output  1  count >= AFULL_LVL.
- rinc  input  1  read request / pop.
- rdata  output  DATASIZE  read data.
- rempty  output  1  count == 0.
- ralmost_empty  output  1  count <= AEMPTY_LVL.
- count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset is the only clock/reset pair: one clock, reset synchronous and active-low.
- On a clk edge with rst_n=0:
  - wptr, rptr and count go to 0.
  - Resulting flags: rempty=1, wfull=0, walmost_full=(AFULL_LVL==0, never true), ralmost_empty=1.
  - overflow=0, underflow=0; rdata register=0 (FWFT=0).
- Memory contents are not reset. Reset mid-operation discards all queued data; the first post-reset write lands at address 0.
- Pointers are ADDRSIZE+1 bits, binary. Address = low ADDRSIZE bits; the MSB disambiguates full from empty on wrap. Wrap from DEPTH-1 to 0 is seamless.
- Write accept: we = winc && !wfull. On accept: mem[waddr] <= wdata; wptr increments.
- Read accept: re = rinc && !rempty. On accept, rptr increments.
- All flags are decided on pre-edge state. Simultaneous rinc and winc:
  - Empty: write accepted, read rejected (underflow set).
  - Full: read accepted, write rejected (overflow set).
  - Otherwise: both accepted, count unchanged.
- count update: next = count + we - re. Flags are combinational compares of registered count. No flag combinationally depends on winc or rinc.
- FWFT=0:
  - rdata is a register loaded with mem[raddr] on the edge where re=1; latency 1 cycle.
  - rdata holds its value otherwise, including when rempty.
- FWFT=1:
  - rdata = mem[raddr] combinationally; valid whenever rempty=0.
  - The re edge advances to the next word. rdata is don't-care when rempty=1.
- Sticky flags:
  - overflow <= 1 on (winc && wfull).
  - underflow <= 1 on (rinc && rempty).
  - clr_err=1 clears both that edge; a new error event in the same cycle as clr_err wins (flag sets).
- Rejected accesses never modify pointers, count or memory.

Decomposition:
- Shared package fifo_pkg:
  - Read-mode constants FIFO_STD=0, FIFO_FWFT=1.
  - Function depth(addrsize).
- One natural sub-module: fifomem_1clk. Single-clock memory array with write enable, async read port, params DATASIZE/ADDRSIZE.
- Pointer, count, flag and read-register logic stays in sync_fifo_flags.

Test Plan (ADDRSIZE=2, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1, DATASIZE=8 unless stated):
- Reset then idle -> rempty=1, wfull=0, count=0, ralmost_empty=1, walmost_full=0, overflow=underflow=0.
- FWFT=0, write 0xA1,0xA2,0xA3,0xA4 on consecutive edges:
  - count 1,2,3,4; walmost_full rises at count=3; wfull rises at count=4.
  - 5th write 0xA5 -> count stays 4, overflow=1.
- Then 4 reads -> rdata 0xA1..0xA4, each one cycle after its rinc edge. Reading 5th time -> underflow=1 and rdata holds 0xA4.
- Wrap: 6 write/read pairs interleaved (count 0..1) -> data order preserved across the address 3 to 0 wrap; rempty toggles correctly.
- Simultaneous: at count=4, winc+rinc -> read accepted, write rejected, count=3, overflow=1. At count=2, winc+rinc -> count stays 2.
- FWFT=1:
  - Write 0x5C into empty FIFO -> next cycle rempty=0 and rdata=0x5C with no rinc.
  - rinc pops -> rempty=1.
  - Assert rst_n=0 while count=3 -> next edge count=0, rempty=1, first write after reset read back correctly.
